// File: rtl/hs_mon_pkg.sv
// Shared definitions for the rdy/acpt channel monitor: error-bit indices
// and the per-channel FSM state encoding.
package hs_mon_pkg;

   localparam int ERR_HOLD    = 0;
   localparam int ERR_DROP    = 1;
   localparam int ERR_TIMEOUT = 2;
   localparam int ERR_W       = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } mon_state_e;

endpackage

// File: rtl/hs_chan_mon.sv
// Single-channel rdy/acpt monitor: stall tracking, hold/drop/timeout error
// detection, saturating event counters and longest-stall capture.
module hs_chan_mon
   import hs_mon_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int SHORT_MAX = 10,
   parameter int TIMEOUT   = 256,
   parameter int CNT_W     = 9,
   parameter int MS_W      = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr_i,
   input  logic              rdy_i,
   input  logic              acpt_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [CNT_W-1:0]  xfer_cnt_o,
   output logic [CNT_W-1:0]  short_cnt_o,
   output logic [CNT_W-1:0]  long_cnt_o,
   output logic [MS_W-1:0]   max_stall_o,
   output logic [ERR_W-1:0]  err_o
);

   localparam logic [MS_W-1:0] LEN_ONE  = MS_W'(1);
   localparam logic [MS_W-1:0] LEN_TO   = MS_W'(TIMEOUT);
   localparam logic [MS_W-1:0] LEN_SHRT = MS_W'(SHORT_MAX);

   mon_state_e        state_q;
   logic [MS_W-1:0]   len_q;
   logic [DATA_W-1:0] held_q;
   logic [CNT_W-1:0]  xfer_q, short_q, long_q;
   logic [MS_W-1:0]   max_q;
   logic [ERR_W-1:0]  err_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Clear shares the reset path: both abandon any stall without counting it.
   always_ff @(posedge clk) begin
      if (!reset_n || clr_i) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         held_q  <= '0;
         xfer_q  <= '0;
         short_q <= '0;
         long_q  <= '0;
         max_q   <= '0;
         err_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rdy_i && acpt_i) begin
                  xfer_q <= sat_inc(xfer_q);
               end else if (rdy_i) begin
                  state_q <= ST_STALL;
                  len_q   <= LEN_ONE;
                  held_q  <= data_i;
                  if (LEN_ONE == LEN_TO) err_q[ERR_TIMEOUT] <= 1'b1;
               end
            end
            ST_STALL: begin
               if (rdy_i && (data_i != held_q)) err_q[ERR_HOLD] <= 1'b1;
               if (!rdy_i) begin
                  err_q[ERR_DROP] <= 1'b1;
                  if (len_q > max_q) max_q <= len_q;
                  state_q <= ST_IDLE;
                  len_q   <= '0;
               end else if (acpt_i) begin
                  xfer_q <= sat_inc(xfer_q);
                  if (len_q <= LEN_SHRT) short_q <= sat_inc(short_q);
                  else                   long_q  <= sat_inc(long_q);
                  if (len_q > max_q) max_q <= len_q;
                  state_q <= ST_IDLE;
                  len_q   <= '0;
               end else if (len_q != LEN_TO) begin
                  // Saturating at TIMEOUT makes the timeout edge unique per stall.
                  len_q <= len_q + LEN_ONE;
                  if (len_q + LEN_ONE == LEN_TO) err_q[ERR_TIMEOUT] <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign xfer_cnt_o  = xfer_q;
   assign short_cnt_o = short_q;
   assign long_cnt_o  = long_q;
   assign max_stall_o = max_q;
   assign err_o       = err_q;

endmodule

// File: rtl/hs_chan_monitor_array.sv
// Array of rdy/acpt channel monitors with a combinational readout mux for
// the selected channel and a registered, masked error interrupt.
module hs_chan_monitor_array
   import hs_mon_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int DATA_W    = 8,
   parameter int SHORT_MAX = 10,
   parameter int TIMEOUT   = 256,
   parameter int CNT_W     = 9,
   localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int MS_W     = $clog2(TIMEOUT + 1)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_CH-1:0]        rdy,
   input  logic [NUM_CH-1:0]        acpt,
   input  logic [NUM_CH*DATA_W-1:0] data,
   input  logic                     clr,
   input  logic [SEL_W-1:0]         sel_ch,
   input  logic [ERR_W-1:0]         err_mask,
   output logic [NUM_CH*ERR_W-1:0]  err_sticky,
   output logic                     irq,
   output logic [CNT_W-1:0]         xfer_cnt,
   output logic [CNT_W-1:0]         short_cnt,
   output logic [CNT_W-1:0]         long_cnt,
   output logic [MS_W-1:0]          max_stall
);

   logic [NUM_CH-1:0][CNT_W-1:0] xfer_a, short_a, long_a;
   logic [NUM_CH-1:0][MS_W-1:0]  max_a;
   logic [NUM_CH-1:0][ERR_W-1:0] err_a;
   logic                         irq_q;
   logic                         irq_d;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      hs_chan_mon #(
         .DATA_W    (DATA_W),
         .SHORT_MAX (SHORT_MAX),
         .TIMEOUT   (TIMEOUT),
         .CNT_W     (CNT_W),
         .MS_W      (MS_W)
      ) u_mon (
         .clk         (clk),
         .reset_n     (reset_n),
         .clr_i       (clr),
         .rdy_i       (rdy[g]),
         .acpt_i      (acpt[g]),
         .data_i      (data[g*DATA_W +: DATA_W]),
         .xfer_cnt_o  (xfer_a[g]),
         .short_cnt_o (short_a[g]),
         .long_cnt_o  (long_a[g]),
         .max_stall_o (max_a[g]),
         .err_o       (err_a[g])
      );
      assign err_sticky[g*ERR_W +: ERR_W] = err_a[g];
   end

   // Unpopulated select codes read back as zero.
   always_comb begin
      xfer_cnt  = '0;
      short_cnt = '0;
      long_cnt  = '0;
      max_stall = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel_ch == SEL_W'(i)) begin
            xfer_cnt  = xfer_a[i];
            short_cnt = short_a[i];
            long_cnt  = long_a[i];
            max_stall = max_a[i];
         end
      end
   end

   always_comb begin
      irq_d = 1'b0;
      for (int i = 0; i < NUM_CH; i++) irq_d = irq_d | (|(err_a[i] & err_mask));
   end

   always_ff @(posedge clk) begin
      if (!reset_n || clr) irq_q <= 1'b0;
      else                 irq_q <= irq_d;
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_hs_chan_monitor_array.sv
// Directed bench for hs_chan_monitor_array (defaults: 2 channels, 8-bit data,
// SHORT_MAX=10, TIMEOUT=256, CNT_W=9) with hand-computed expectations.
module tb_hs_chan_monitor_array;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  rdy, acpt;
   logic [15:0] data;
   logic        clr;
   logic [0:0]  sel_ch;
   logic [2:0]  err_mask;
   logic [5:0]  err_sticky;
   logic        irq;
   logic [8:0]  xfer_cnt, short_cnt, long_cnt, max_stall;

   int checks = 0;
   int errors = 0;

   hs_chan_monitor_array dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rdy        (rdy),
      .acpt       (acpt),
      .data       (data),
      .clr        (clr),
      .sel_ch     (sel_ch),
      .err_mask   (err_mask),
      .err_sticky (err_sticky),
      .irq        (irq),
      .xfer_cnt   (xfer_cnt),
      .short_cnt  (short_cnt),
      .long_cnt   (long_cnt),
      .max_stall  (max_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; rdy = '0; acpt = '0; data = '0; clr = 1'b0;
      sel_ch = '0; err_mask = '0;
      step(2);
      chk("rst_xfer",  xfer_cnt,   0);
      chk("rst_short", short_cnt,  0);
      chk("rst_long",  long_cnt,   0);
      chk("rst_max",   max_stall,  0);
      chk("rst_err",   err_sticky, 0);
      chk("rst_irq",   irq,        0);
      reset_n = 1'b1;

      // 3 stall cycles, accept on the 4th rdy cycle
      rdy[0] = 1'b1; data[7:0] = 8'h11;
      step(3);
      acpt[0] = 1'b1;
      step();
      rdy[0] = 1'b0; acpt[0] = 1'b0;
      step();
      chk("s1_short", short_cnt,        1);
      chk("s1_xfer",  xfer_cnt,         1);
      chk("s1_long",  long_cnt,         0);
      chk("s1_max",   max_stall,        3);
      chk("s1_err",   err_sticky[2:0],  0);
      pulse_clr();
      chk("clr_xfer", xfer_cnt,  0);
      chk("clr_max",  max_stall, 0);

      // 12 stalls -> long; then 10 stalls -> short (boundary)
      rdy[0] = 1'b1;
      step(12);
      acpt[0] = 1'b1;
      step();
      rdy[0] = 1'b0; acpt[0] = 1'b0;
      step();
      chk("s2_long",  long_cnt,  1);
      chk("s2_max",   max_stall, 12);
      chk("s2_short", short_cnt, 0);
      rdy[0] = 1'b1;
      step(10);
      acpt[0] = 1'b1;
      step();
      rdy[0] = 1'b0; acpt[0] = 1'b0;
      step();
      chk("s2b_short", short_cnt, 1);
      chk("s2b_long",  long_cnt,  1);
      chk("s2b_max",   max_stall, 12);
      chk("s2b_xfer",  xfer_cnt,  2);
      pulse_clr();

      // data changes mid-stall -> hold error, irq one cycle later
      err_mask = 3'b001;
      rdy[0] = 1'b1; data[7:0] = 8'h5A;
      step(2);
      chk("s3_pre", err_sticky[2:0], 0);
      data[7:0] = 8'hA5;
      step();
      chk("s3_hold",    err_sticky[2:0], 3'b001);
      chk("s3_irq_lag", irq, 0);
      step();
      chk("s3_irq", irq, 1);
      acpt[0] = 1'b1;
      step();
      rdy[0] = 1'b0; acpt[0] = 1'b0;
      pulse_clr();
      chk("s3_clr_irq", irq, 0);
      chk("s3_clr_err", err_sticky, 0);
      err_mask = 3'b000;

      // rdy withdrawn after 2 stall cycles
      rdy[0] = 1'b1;
      step(2);
      rdy[0] = 1'b0;
      step();
      chk("s4_drop",  err_sticky[2:0], 3'b010);
      chk("s4_xfer",  xfer_cnt,  0);
      chk("s4_short", short_cnt, 0);
      chk("s4_long",  long_cnt,  0);
      chk("s4_max",   max_stall, 2);
      chk("s4_irq",   irq, 0);
      pulse_clr();

      // 300-cycle stall: timeout exactly at cycle 256, length saturates
      rdy[0] = 1'b1; data[7:0] = 8'h33;
      step(255);
      chk("s5_pre_to", err_sticky[2:0], 0);
      step();
      chk("s5_to", err_sticky[2:0], 3'b100);
      step(44);
      acpt[0] = 1'b1;
      step();
      rdy[0] = 1'b0; acpt[0] = 1'b0;
      step();
      chk("s5_err",  err_sticky[2:0], 3'b100);
      chk("s5_max",  max_stall, 256);
      chk("s5_long", long_cnt,  1);
      pulse_clr();

      // reset mid-stall abandons it silently
      rdy[0] = 1'b1;
      step(2);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1; rdy[0] = 1'b0;
      step();
      chk("s6_err", err_sticky, 0);
      chk("s6_max", max_stall,  0);

      // channel 1: 600 back-to-back transfers saturate at 511
      sel_ch = 1'b1;
      rdy[1] = 1'b1; acpt[1] = 1'b1;
      step(600);
      chk("s7_sat", xfer_cnt, 511);
      sel_ch = 1'b0;
      #1;
      chk("s7_ch0", xfer_cnt, 0);
      sel_ch = 1'b1;
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("s7_clr_xfer", xfer_cnt, 0);
      chk("s7_clr_err",  err_sticky, 0);
      step();
      chk("s7_after", xfer_cnt, 1);
      rdy = '0; acpt = '0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hs_chan_monitor_array.md
HS_CHAN_MONITOR_ARRAY -- requirements
Module: hs_chan_monitor_array

Interface
REQ-001 SHALL take parameter NUM_CH, default 2, the number of monitored rdy/acpt channels (1..16).
REQ-002 SHALL take parameter DATA_W, default 8, the data width per channel.
REQ-003 SHALL take parameter SHORT_MAX, default 10, the longest stall (in cycles) classed "short".
REQ-004 SHALL take parameter TIMEOUT, default 256, the stall length that flags a timeout (TIMEOUT > SHORT_MAX).
REQ-005 SHALL take parameter CNT_W, default 9, the width of the event counters.
REQ-006 SHALL have clk, input, 1 bit: single clock; all logic samples on its rising edge.
REQ-007 SHALL have reset_n, input, 1 bit: synchronous active-low reset.
REQ-008 SHALL have rdy, input, NUM_CH bits: per-channel ready (data valid).
REQ-009 SHALL have acpt, input, NUM_CH bits: per-channel accept.
REQ-010 SHALL have data, input, NUM_CH*DATA_W bits: channel i occupies bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have clr, input, 1 bit: a one-cycle pulse that zeroes all counters, max registers and sticky errors.
REQ-012 SHALL have sel_ch, input, $clog2(NUM_CH) bits (minimum 1): selects the channel shown on the readout ports.
REQ-013 SHALL have err_mask, input, 3 bits: interrupt enable for {timeout, drop, hold}.
REQ-014 SHALL have err_sticky, output, NUM_CH*3 bits: per channel {timeout, drop, hold}.
REQ-015 SHALL have irq, output, 1 bit: OR over all channels of (err_sticky & err_mask), registered.
REQ-016 SHALL have xfer_cnt, short_cnt, long_cnt, outputs, CNT_W bits each: readout for sel_ch.
REQ-017 SHALL have max_stall, output, $clog2(TIMEOUT+1) bits: readout for sel_ch.

Function
REQ-018 SHALL count a transfer on a channel in any cycle where rdy=1 and acpt=1.
REQ-019 SHALL treat a cycle with rdy=1 and acpt=0 as a stall cycle.
REQ-020 SHALL give each channel a 2-state FSM: IDLE -> STALL on a stall cycle; STALL stays while stall cycles continue.
REQ-021 SHALL leave STALL to IDLE on a transfer or when rdy=0.
REQ-022 SHALL latch data into a held register on IDLE->STALL; stall_len is 1 on entry, +1 per further stall cycle, saturating at TIMEOUT.
REQ-023 SHALL set hold_err in STALL when rdy=1 and data differs from the held value; the held value does not update.
REQ-024 SHALL set drop_err in STALL when rdy=0 (rdy withdrawn before accept).
REQ-025 SHALL set timeout_err in the cycle stall_len becomes TIMEOUT, once per stall.
REQ-026 SHALL, on a transfer that ends a stall, increment short_cnt if stall_len <= SHORT_MAX, else long_cnt.
REQ-027 SHALL count a transfer with no preceding stall in xfer_cnt only.
REQ-028 SHALL update max_stall to stall_len when a stall ends (transfer or drop) and stall_len exceeds max_stall.
REQ-029 SHALL saturate all counters at all-ones; they never wrap.
REQ-030 SHALL make error bits sticky until clr or reset.
REQ-031 SHALL give clr priority when it coincides with an event: all state is cleared and the event is not counted; the FSM also returns to IDLE.
REQ-032 SHALL present readout ports combinationally from the selected channel's registers, so counts are visible one cycle after the event edge.
REQ-033 SHALL assert irq one cycle after the enabled sticky bit sets.

Reset
REQ-034 SHALL, when reset_n=0 at a clk edge, return every FSM to IDLE and set stall_len, counters, max_stall, err_sticky and irq to 0.
REQ-035 SHALL abandon a stall in progress at reset, with no error and no count.
REQ-036 SHALL reset no datapath register other than the held-data register, which resets to 0.

Structure
REQ-037 SHALL place the error-bit index constants (HOLD=0, DROP=1, TIMEOUT=2) and the FSM state enum in a shared package, hs_mon_pkg.
REQ-038 SHALL implement one channel in sub-module hs_chan_mon, generated NUM_CH times; the top holds the readout mux and irq reduction.

Verification
REQ-039 SHALL verify: rdy=1 for 4 cycles with acpt rising in cycle 4 -> short_cnt=1, xfer_cnt=1, max_stall=3, no errors.
REQ-040 SHALL verify: 12 stall cycles then acpt -> long_cnt=1, max_stall=12.
REQ-041 SHALL verify: data changes 0x5A->0xA5 mid-stall with err_mask=3'b001 -> hold bit set; irq=1 one cycle later.
REQ-042 SHALL verify: rdy dropped after 2 stall cycles -> drop bit set; no transfer or stall counted; max_stall=2.
REQ-043 SHALL verify: 300 stall cycles with TIMEOUT=256 -> timeout bit set exactly at cycle 256; max_stall saturates at 256.
REQ-044 SHALL verify: 600 back-to-back transfers with CNT_W=9 -> xfer_cnt=511; a clr coincident with a transfer leaves all counts at 0.
